test_monitor: RTL and testbench

Synthesizable end-of-test detector for the RISC-V core's ISA regression flow. It snoops the register-file write port inside `soc` and tracks the test-number register (x3), the finish flag (x26) and the result register (x27). When x26 is written with 1 it waits a fixed drain window, then latches a pass/fail verdict, the failing case number and the cycle count. The core's write port feeds it; the verdict outputs feed the simulation bench and the board status LEDs.

---
 rtl/test_monitor.sv | 123 ++++++++++++
 tb/tb_test_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// End-of-test detector: snoops register-file writes for the ISA test flag,
// waits out a drain window, then latches a sticky pass/fail verdict.
module test_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter logic [4:0]  CASE_REG       = 5'd3,
    parameter logic [4:0]  FLAG_REG       = 5'd26,
    parameter logic [4:0]  RESULT_REG     = 5'd27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] fail_case,
    output logic [31:0] cycle_cnt
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  DRAIN_LOAD   = 4'(DRAIN_CYCLES);
    localparam logic        TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);

    state_t      r_state;
    logic [3:0]  r_drain;
    logic [31:0] r_case;
    logic [31:0] r_res;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic [31:0] r_failCase;
    logic [31:0] r_cycle;

    logic        w_wr;
    logic        w_flag;
    logic        w_timeoutHit;
    logic [31:0] w_cycleNext;

    // x0 writes never count, even if a parameter happens to name register 0
    assign w_wr         = wr_en && (wr_addr != 5'd0);
    assign w_flag       = w_wr && (wr_addr == FLAG_REG) && (wr_data == 32'h1);
    assign w_timeoutHit = TIMEOUT_ON && (r_cycle == TIMEOUT_LAST);
    assign w_cycleNext  = (r_cycle == 32'hFFFF_FFFF) ? r_cycle : r_cycle + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_drain    <= 4'd0;
            r_case     <= 32'd0;
            r_res      <= 32'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_failCase <= 32'd0;
            r_cycle    <= 32'd0;
        end else if (clr) begin
            r_state    <= RUN;
            r_drain    <= 4'd0;
            r_case     <= 32'd0;
            r_res      <= 32'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_failCase <= 32'd0;
            r_cycle    <= 32'd0;
        end else begin
            if ((r_state != DONE) && w_wr) begin
                if (wr_addr == CASE_REG)   r_case <= wr_data;
                if (wr_addr == RESULT_REG) r_res  <= wr_data;
            end

            // The verdict edge itself is not counted, so cycle_cnt holds there
            case (r_state)
                RUN: begin
                    if (w_flag) begin
                        r_state <= DRAIN;
                        r_drain <= DRAIN_LOAD;
                        r_cycle <= w_cycleNext;
                    end else if (w_timeoutHit) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_failCase <= r_case;
                    end else begin
                        r_cycle <= w_cycleNext;
                    end
                end
                DRAIN: begin
                    if (r_drain == 4'd0) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_pass     <= (r_res == 32'd1);
                        r_timeout  <= 1'b0;
                        r_failCase <= (r_res == 32'd1) ? 32'd0 : r_case;
                    end else begin
                        r_drain <= r_drain - 4'd1;
                        r_cycle <= w_cycleNext;
                    end
                end
                default: begin
                    r_state <= DONE;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign fail_case = r_failCase;
    assign cycle_cnt = r_cycle;

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor: directed scenarios with hand-derived
// expectations plus randomized write traces checked against a trace-level model.
module tb_test_monitor;

    localparam int TIMEOUT = 20;
    localparam int DRAIN   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] fail_case;
    logic [31:0] cycle_cnt;

    int checkCount = 0;
    int failCount  = 0;

    logic        stEn[$];
    logic [4:0]  stAddr[$];
    logic [31:0] stData[$];

    int          obsDoneEdge;
    logic        obsDone;
    logic        obsPass;
    logic        obsTimeout;
    logic [31:0] obsFail;
    logic [31:0] obsCnt;

    always #5 clk = ~clk;

    test_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .DRAIN_CYCLES  (DRAIN),
        .CASE_REG      (5'd3),
        .FLAG_REG      (5'd26),
        .RESULT_REG    (5'd27)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .fail_case(fail_case),
        .cycle_cnt(cycle_cnt)
    );

    // Leaves the bench at a falling edge with reset released; the next rising edge is edge 1
    task automatic resetDut();
        wr_en = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stEn.delete();
        stAddr.delete();
        stData.delete();
    endtask

    task automatic addWr(input logic [4:0] a, input logic [31:0] d);
        stEn.push_back(1'b1);
        stAddr.push_back(a);
        stData.push_back(d);
    endtask

    task automatic addIdle(input int k);
        for (int i = 0; i < k; i++) begin
            stEn.push_back(1'b0);
            stAddr.push_back(5'd0);
            stData.push_back(32'd0);
        end
    endtask

    // Plays the queued trace one write per edge and records when done first rose
    task automatic applyStimulus();
        obsDoneEdge = 0;
        for (int e = 1; e <= stEn.size(); e++) begin
            wr_en   = stEn[e-1];
            wr_addr = stAddr[e-1];
            wr_data = stData[e-1];
            @(posedge clk);
            #1;
            if (done === 1'b1 && obsDoneEdge == 0) obsDoneEdge = e;
            @(negedge clk);
        end
        wr_en      = 1'b0;
        obsDone    = done;
        obsPass    = pass;
        obsTimeout = timeout;
        obsFail    = fail_case;
        obsCnt     = cycle_cnt;
    endtask

    // Verdict derived from the whole trace: first accepted flag edge, then last shadow writes before the verdict edge
    task automatic modelRun(output int expEdge, output logic ePass, output logic eTo,
                            output logic [31:0] eFail, output logic [31:0] eCnt);
        int flagEdge = 0;
        logic [31:0] cq = 32'd0;
        logic [31:0] rq = 32'd0;
        for (int e = 1; e <= TIMEOUT && e <= stEn.size(); e++) begin
            if (flagEdge == 0 && stEn[e-1] && stAddr[e-1] == 5'd26 && stData[e-1] == 32'd1)
                flagEdge = e;
        end
        eTo     = (flagEdge == 0);
        expEdge = eTo ? TIMEOUT : flagEdge + DRAIN + 1;
        for (int e = 1; e < expEdge; e++) begin
            if (stEn[e-1] && stAddr[e-1] == 5'd3)  cq = stData[e-1];
            if (stEn[e-1] && stAddr[e-1] == 5'd27) rq = stData[e-1];
        end
        ePass = !eTo && (rq == 32'd1);
        eFail = ePass ? 32'd0 : cq;
        eCnt  = 32'(expEdge - 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({done, pass, timeout, fail_case, cycle_cnt} !== 67'd0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got done=%b pass=%b to=%b fc=%0d cnt=%0d expected all 0",
                     done, pass, timeout, fail_case, cycle_cnt);
        end
        resetDut();
    endtask

    task automatic test_pass();
        resetDut();
        addWr(5'd3, 32'd5); addWr(5'd27, 32'd1); addWr(5'd26, 32'd1); addIdle(5);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 6) begin failCount++; $display("[TB] FAIL pass_done_edge: got %0d expected 6", obsDoneEdge); end
        checkCount++;
        if ({obsPass, obsTimeout, obsFail} !== {1'b1, 1'b0, 32'd0}) begin
            failCount++; $display("[TB] FAIL pass_verdict: got pass=%b to=%b fc=%0d expected 1 0 0", obsPass, obsTimeout, obsFail);
        end
        checkCount++;
        if (obsCnt !== 32'd5) begin failCount++; $display("[TB] FAIL pass_cycle_cnt: got %0d expected 5", obsCnt); end
    endtask

    task automatic test_fail();
        resetDut();
        addWr(5'd3, 32'd7); addWr(5'd27, 32'd0); addWr(5'd26, 32'd1); addIdle(5);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 6) begin failCount++; $display("[TB] FAIL fail_done_edge: got %0d expected 6", obsDoneEdge); end
        checkCount++;
        if ({obsPass, obsTimeout, obsFail} !== {1'b0, 1'b0, 32'd7}) begin
            failCount++; $display("[TB] FAIL fail_verdict: got pass=%b to=%b fc=%0d expected 0 0 7", obsPass, obsTimeout, obsFail);
        end
    endtask

    task automatic test_late_write();
        resetDut();
        addWr(5'd26, 32'd1); addIdle(1); addWr(5'd27, 32'd1); addIdle(4);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 4 || obsPass !== 1'b1 || obsCnt !== 32'd3) begin
            failCount++; $display("[TB] FAIL late_write_inside: got edge=%0d pass=%b cnt=%0d expected 4 1 3", obsDoneEdge, obsPass, obsCnt);
        end
        resetDut();
        addWr(5'd26, 32'd1); addIdle(2); addWr(5'd27, 32'd1); addIdle(3);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 4 || obsPass !== 1'b0 || obsFail !== 32'd0) begin
            failCount++; $display("[TB] FAIL late_write_outside: got edge=%0d pass=%b fc=%0d expected 4 0 0", obsDoneEdge, obsPass, obsFail);
        end
    endtask

    task automatic test_timeout();
        resetDut();
        addWr(5'd3, 32'd9); addIdle(24);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== TIMEOUT) begin failCount++; $display("[TB] FAIL timeout_edge: got %0d expected %0d", obsDoneEdge, TIMEOUT); end
        checkCount++;
        if ({obsTimeout, obsPass, obsFail, obsCnt} !== {1'b1, 1'b0, 32'd9, 32'd19}) begin
            failCount++; $display("[TB] FAIL timeout_verdict: got to=%b pass=%b fc=%0d cnt=%0d expected 1 0 9 19",
                                  obsTimeout, obsPass, obsFail, obsCnt);
        end
        resetDut();
        addWr(5'd3, 32'd9); addIdle(TIMEOUT - 2); addWr(5'd26, 32'd1); addIdle(5);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== TIMEOUT + 3 || obsTimeout !== 1'b0 || obsCnt !== 32'(TIMEOUT + 2)) begin
            failCount++; $display("[TB] FAIL timeout_flag_wins: got edge=%0d to=%b cnt=%0d expected %0d 0 %0d",
                                  obsDoneEdge, obsTimeout, obsCnt, TIMEOUT + 3, TIMEOUT + 2);
        end
    endtask

    task automatic test_ignored_writes();
        resetDut();
        addWr(5'd26, 32'd2); addWr(5'd0, 32'd1); addIdle(13);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 0 || obsDone !== 1'b0) begin
            failCount++; $display("[TB] FAIL ignored_flag: got done_edge=%0d done=%b expected 0 0", obsDoneEdge, obsDone);
        end
        checkCount++;
        if (obsCnt !== 32'd15) begin failCount++; $display("[TB] FAIL ignored_cycle_cnt: got %0d expected 15", obsCnt); end
    endtask

    task automatic test_async_reset();
        resetDut();
        addWr(5'd27, 32'd1); addWr(5'd26, 32'd1); addIdle(1);
        applyStimulus();
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({done, pass, timeout, fail_case, cycle_cnt} !== 67'd0) begin
            failCount++; $display("[TB] FAIL async_reset_drain: got done=%b cnt=%0d expected 0 0", done, cycle_cnt);
        end
        resetDut();
        addWr(5'd3, 32'd4); addWr(5'd26, 32'd1); addIdle(4);
        applyStimulus();
        #2;
        rst_n = 1'b0;
        #1;
        checkCount++;
        if ({done, pass, timeout, fail_case, cycle_cnt} !== 67'd0) begin
            failCount++; $display("[TB] FAIL async_reset_done: got done=%b fc=%0d cnt=%0d expected 0 0 0", done, fail_case, cycle_cnt);
        end
        resetDut();
        addWr(5'd3, 32'd5); addWr(5'd27, 32'd1); addWr(5'd26, 32'd1); addIdle(4);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 6 || obsPass !== 1'b1) begin
            failCount++; $display("[TB] FAIL async_reset_rerun: got edge=%0d pass=%b expected 6 1", obsDoneEdge, obsPass);
        end
    endtask

    task automatic test_clr();
        resetDut();
        addWr(5'd3, 32'd6); addWr(5'd26, 32'd1); addIdle(4);
        applyStimulus();
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if ({done, pass, timeout, fail_case, cycle_cnt} !== 67'd0) begin
            failCount++; $display("[TB] FAIL clr_in_done: got done=%b fc=%0d cnt=%0d expected 0 0 0", done, fail_case, cycle_cnt);
        end
        @(negedge clk);
        clr = 1'b0;
        stEn.delete(); stAddr.delete(); stData.delete();
        addWr(5'd27, 32'd1); addWr(5'd26, 32'd1); addIdle(4);
        applyStimulus();
        checkCount++;
        if (obsDoneEdge !== 5 || obsPass !== 1'b1 || obsCnt !== 32'd4) begin
            failCount++; $display("[TB] FAIL clr_rerun: got edge=%0d pass=%b cnt=%0d expected 5 1 4", obsDoneEdge, obsPass, obsCnt);
        end
    endtask

    task automatic test_random();
        int          expEdge;
        logic        ePass;
        logic        eTo;
        logic [31:0] eFail;
        logic [31:0] eCnt;
        logic [4:0]  a;
        logic [31:0] d;
        for (int it = 0; it < 24; it++) begin
            resetDut();
            for (int e = 0; e < 30; e++) begin
                case ($urandom_range(0, 5))
                    0:       a = 5'd0;
                    1:       a = 5'd3;
                    2:       a = 5'd26;
                    3:       a = 5'd27;
                    4:       a = 5'($urandom);
                    default: a = 5'd27;
                endcase
                if ((it % 4) == 0 && a == 5'd26) a = 5'd3;
                case ($urandom_range(0, 3))
                    0:       d = 32'd0;
                    1:       d = 32'd1;
                    2:       d = 32'd2;
                    default: d = $urandom;
                endcase
                if ($urandom_range(0, 3) == 0) addIdle(1);
                else                           addWr(a, d);
            end
            modelRun(expEdge, ePass, eTo, eFail, eCnt);
            applyStimulus();
            checkCount++;
            if (obsDoneEdge !== expEdge || obsDone !== 1'b1) begin
                failCount++; $display("[TB] FAIL rand_done it=%0d: got edge=%0d done=%b expected %0d 1", it, obsDoneEdge, obsDone, expEdge);
            end
            checkCount++;
            if ({obsPass, obsTimeout, obsFail, obsCnt} !== {ePass, eTo, eFail, eCnt}) begin
                failCount++; $display("[TB] FAIL rand_verdict it=%0d: got pass=%b to=%b fc=%0h cnt=%0d expected %b %b %0h %0d",
                                      it, obsPass, obsTimeout, obsFail, obsCnt, ePass, eTo, eFail, eCnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_late_write();
        test_timeout();
        test_ignored_writes();
        test_async_reset();
        test_clr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
